// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the single io_register access port between N_REQ requesters.
// Fixed priority (lowest index wins) with a starvation override; one transaction every 3 cycles.
//
// state  | meaning
// IDLE   | no transaction; arbitrate among req and latch the winner's access
// ACCESS | latched access driven onto io_* for exactly one cycle
// RESP   | one-cycle ack to the granted requester
module io_bus_arbiter #(
  parameter int N_REQ        = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk_mem,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*24-1:0] req_addr,
  input  logic [N_REQ*32-1:0] req_wdata,
  input  logic [N_REQ-1:0]    req_read,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*2-1:0]  req_width,
  output logic [N_REQ-1:0]    ack,
  output logic [31:0]         rdata,
  output logic [1:0]          grant_id,
  output logic                busy,
  output logic [23:0]         io_addr,
  output logic [31:0]         io_data_in,
  input  logic [31:0]         io_data_out,
  output logic                io_read,
  output logic                io_write,
  output logic [1:0]          io_width
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic [CW-1:0] starve_cnt [N_REQ];
  logic          win_valid;
  logic [1:0]    win_id;
  logic          lat_read;
  logic          lat_write;

  always_comb begin
    win_valid = |req;
    win_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i]) win_id = 2'(i);
    // second pass lets a starved requester override plain priority (lowest starved index wins)
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[i] && starve_cnt[i] >= LIMIT) win_id = 2'(i);
  end

  always_ff @(posedge clk_mem) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    io_read   = 1'b0;
    io_write  = 1'b0;
    ack       = '0;
    case (state)
      IDLE: begin
        if (win_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        io_write  = lat_write;
        io_read   = lat_read & ~lat_write;
        state_nxt = RESP;
      end
      RESP: begin
        busy = 1'b1;
        for (int i = 0; i < N_REQ; i++) ack[i] = (grant_id == 2'(i));
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_mem) begin
    if (rst) begin
      grant_id   <= '0;
      io_addr    <= '0;
      io_data_in <= '0;
      io_width   <= '0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      rdata      <= '0;
      for (int i = 0; i < N_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      if (state == IDLE) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (!req[i] || win_id == 2'(i)) starve_cnt[i] <= '0;
          else if (starve_cnt[i] < LIMIT) starve_cnt[i] <= starve_cnt[i] + CW'(1);
        end
        if (win_valid) begin
          grant_id   <= win_id;
          io_addr    <= req_addr[int'(win_id)*24 +: 24];
          io_data_in <= req_wdata[int'(win_id)*32 +: 32];
          io_width   <= req_width[int'(win_id)*2 +: 2];
          lat_read   <= req_read[win_id];
          lat_write  <= req_write[win_id];
        end
      end
      if (state == ACCESS && io_read) rdata <= io_data_out;
    end
  end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model of the arbitration and access rules.
module tb_io_bus_arbiter;
  localparam int N      = 3;
  localparam int STARVE = 4;

  logic            clk_mem = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_read, req_write;
  logic [N*24-1:0] req_addr;
  logic [N*32-1:0] req_wdata;
  logic [N*2-1:0]  req_width;
  logic [N-1:0]    ack;
  logic [31:0]     rdata;
  logic [1:0]      grant_id;
  logic            busy;
  logic [23:0]     io_addr;
  logic [31:0]     io_data_in;
  logic [31:0]     io_data_out;
  logic            io_read, io_write;
  logic [1:0]      io_width;

  logic        use_fixed;
  logic [31:0] fixed_val;
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_rdata;
  int          cnt [N];
  logic [23:0] s_addr  [N];
  logic [31:0] s_wdata [N];
  logic        s_read  [N];
  logic        s_write [N];
  logic [1:0]  s_width [N];

  always #5 clk_mem = ~clk_mem;

  function automatic logic [31:0] io_fn(input logic [23:0] a);
    return {a[7:0] ^ 8'h3C, a};
  endfunction

  // stand-in for io_register: combinational read data
  always_comb io_data_out = use_fixed ? fixed_val : io_fn(io_addr);

  io_bus_arbiter #(.N_REQ(N), .STARVE_LIMIT(STARVE)) dut (
    .clk_mem(clk_mem), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_read(req_read), .req_write(req_write), .req_width(req_width), .ack(ack),
    .rdata(rdata), .grant_id(grant_id), .busy(busy), .io_addr(io_addr),
    .io_data_in(io_data_in), .io_data_out(io_data_out), .io_read(io_read),
    .io_write(io_write), .io_width(io_width));

  task automatic cyc();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic set_slot(input int i, input logic r, input logic w, input logic [23:0] a,
                          input logic [31:0] d, input logic [1:0] wd);
    req_read[i] = r;
    req_write[i] = w;
    req_addr[i*24 +: 24] = a;
    req_wdata[i*32 +: 32] = d;
    req_width[i*2 +: 2] = wd;
    s_read[i] = r; s_write[i] = w; s_addr[i] = a; s_wdata[i] = d; s_width[i] = wd;
  endtask

  // starved requesters first, else lowest index; losers age (saturating), others clear
  function automatic int model_pick(input logic [N-1:0] r);
    int w = -1;
    for (int i = 0; i < N; i++) if (w < 0 && r[i] && cnt[i] >= STARVE) w = i;
    for (int i = 0; i < N; i++) if (w < 0 && r[i]) w = i;
    for (int i = 0; i < N; i++)
      cnt[i] = (!r[i] || i == w) ? 0 : ((cnt[i] < STARVE) ? cnt[i] + 1 : STARVE);
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = '0; req_read = '0; req_write = '0;
    req_addr = '0; req_wdata = '0; req_width = '0;
    use_fixed = 1'b1; fixed_val = 32'hFFFF_FFFF;
    repeat (3) cyc();
    n_checks++;
    if ({ack, busy, io_read, io_write, grant_id} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %h want 00", {ack, busy, io_read, io_write, grant_id});
    end
    n_checks++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++;
    if ({io_addr, io_data_in, io_width} !== 58'h0) begin
      n_fail++; $display("FAIL reset_io: got %h want 0", {io_addr, io_data_in, io_width});
    end
    rst = 1'b0;
    exp_rdata = 32'h0;
  endtask

  task automatic test_cpu_read();
    use_fixed = 1'b1; fixed_val = 32'h00A5_0000;
    set_slot(0, 1'b1, 1'b0, 24'h000004, 32'h0, 2'b10); req[0] = 1'b1;
    cyc();
    n_checks++;
    if ({busy, io_read, io_write, grant_id, io_addr, ack} !== {1'b1, 1'b1, 1'b0, 2'd0, 24'h000004, 3'b000}) begin
      n_fail++; $display("FAIL cpu_read_access: got %h want %h", {busy, io_read, io_write, grant_id, io_addr, ack},
                         {1'b1, 1'b1, 1'b0, 2'd0, 24'h000004, 3'b000});
    end
    cyc();
    n_checks++;
    if ({ack, io_read, io_write, rdata} !== {3'b001, 1'b0, 1'b0, 32'h00A5_0000}) begin
      n_fail++; $display("FAIL cpu_read_ack: got %h want %h", {ack, io_read, io_write, rdata}, {3'b001, 2'b00, 32'h00A5_0000});
    end
    req[0] = 1'b0;
    exp_rdata = 32'h00A5_0000;
    cyc();
    n_checks++;
    if ({busy, ack, io_read, io_write} !== 6'b0) begin
      n_fail++; $display("FAIL cpu_read_after: got %b want 000000", {busy, ack, io_read, io_write});
    end
  endtask

  task automatic test_dma_write();
    set_slot(1, 1'b0, 1'b1, 24'h000100, 32'h00C0_0010, 2'b10); req[1] = 1'b1;
    cyc();
    n_checks++;
    if ({io_write, io_read, grant_id, io_addr, io_data_in, io_width} !== {1'b1, 1'b0, 2'd1, 24'h000100, 32'h00C0_0010, 2'd2}) begin
      n_fail++; $display("FAIL dma_write_access: got %h want %h", {io_write, io_read, grant_id, io_addr, io_data_in, io_width},
                         {1'b1, 1'b0, 2'd1, 24'h000100, 32'h00C0_0010, 2'd2});
    end
    cyc();
    n_checks++;
    if ({ack, io_write, rdata} !== {3'b010, 1'b0, exp_rdata}) begin
      n_fail++; $display("FAIL dma_write_ack: got %h want %h", {ack, io_write, rdata}, {3'b010, 1'b0, exp_rdata});
    end
    req[1] = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    int exp;
    int w;
    use_fixed = 1'b1; fixed_val = 32'h1234_5678;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    set_slot(0, 1'b1, 1'b0, 24'h000010, 32'h0, 2'b10);
    set_slot(1, 1'b1, 1'b0, 24'h000020, 32'h0, 2'b10);
    req = 3'b011;
    for (int k = 0; k < 10; k++) begin
      exp = model_pick(req);
      cyc();
      w = 1;
      while (!(io_read || io_write) && w < 8) begin cyc(); w++; end
      n_checks++;
      if (!(io_read || io_write)) begin n_fail++; $display("FAIL starve_timeout: arb %0d no access within %0d cycles", k, w); end
      n_checks++;
      if (grant_id !== 2'(exp)) begin n_fail++; $display("FAIL starve_grant: arb %0d got %0d want %0d", k, grant_id, exp); end
      cyc();
      n_checks++;
      if ({ack, rdata} !== {3'(1 << exp), 32'h1234_5678}) begin
        n_fail++; $display("FAIL starve_ack: arb %0d got %h want %h", k, {ack, rdata}, {3'(1 << exp), 32'h1234_5678});
      end
      if (k == 9) req = '0;
    end
    exp_rdata = 32'h1234_5678;
    cyc();
  endtask

  task automatic test_rw_both();
    use_fixed = 1'b1; fixed_val = 32'hDEAD_BEEF;
    set_slot(2, 1'b1, 1'b1, 24'h000044, 32'hA5A5_0F0F, 2'b00); req[2] = 1'b1;
    cyc();
    n_checks++;
    if ({io_write, io_read, io_data_in} !== {1'b1, 1'b0, 32'hA5A5_0F0F}) begin
      n_fail++; $display("FAIL rw_both_access: got %h want %h", {io_write, io_read, io_data_in}, {2'b10, 32'hA5A5_0F0F});
    end
    cyc();
    n_checks++;
    if ({ack, rdata} !== {3'b100, exp_rdata}) begin
      n_fail++; $display("FAIL rw_both_ack: got %h want %h", {ack, rdata}, {3'b100, exp_rdata});
    end
    req[2] = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    set_slot(1, 1'b0, 1'b1, 24'h000200, 32'h0000_0055, 2'b01); req[1] = 1'b1;
    cyc();
    n_checks++;
    if (io_write !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: io_write got %b want 1", io_write); end
    rst = 1'b1; req[1] = 1'b0;
    cyc();
    n_checks++;
    if ({io_write, io_read, busy, ack, rdata} !== {6'b0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_abort: got %h want 0", {io_write, io_read, busy, ack, rdata});
    end
    rst = 1'b0; exp_rdata = 32'h0;
    cyc();
    n_checks++;
    if ({busy, ack, io_write} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 00000", {busy, ack, io_write}); end
    fixed_val = 32'h0BAD_F00D;
    set_slot(0, 1'b1, 1'b0, 24'h000008, 32'h0, 2'b10); req[0] = 1'b1;
    cyc();
    n_checks++;
    if ({io_read, io_addr} !== {1'b1, 24'h000008}) begin
      n_fail++; $display("FAIL rst_mid_fresh_access: got %h want %h", {io_read, io_addr}, {1'b1, 24'h000008});
    end
    cyc();
    n_checks++;
    if ({ack, rdata} !== {3'b001, 32'h0BAD_F00D}) begin
      n_fail++; $display("FAIL rst_mid_fresh_ack: got %h want %h", {ack, rdata}, {3'b001, 32'h0BAD_F00D});
    end
    req[0] = 1'b0; exp_rdata = 32'h0BAD_F00D;
    cyc();
  endtask

  task automatic test_drop_req();
    int extra = 0;
    fixed_val = 32'h0077_0077;
    set_slot(2, 1'b1, 1'b0, 24'h000030, 32'h0, 2'b01); req[2] = 1'b1;
    cyc();
    n_checks++;
    if (io_read !== 1'b1) begin n_fail++; $display("FAIL drop_access: io_read got %b want 1", io_read); end
    req[2] = 1'b0;
    cyc();
    n_checks++;
    if ({ack, rdata} !== {3'b100, 32'h0077_0077}) begin
      n_fail++; $display("FAIL drop_ack: got %h want %h", {ack, rdata}, {3'b100, 32'h0077_0077});
    end
    exp_rdata = 32'h0077_0077;
    repeat (4) begin
      cyc();
      if (ack !== 3'b0 || busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL drop_no_second: busy/ack cycles got %0d want 0", extra); end
  endtask

  task automatic new_req(input int i);
    int rw = $urandom_range(3, 0);
    set_slot(i, rw[0], rw[1], 24'($urandom), $urandom, 2'($urandom_range(3, 0)));
    req[i] = 1'b1;
  endtask

  task automatic test_random();
    int phase = 0;
    int g = 0;
    int w;
    logic [23:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [1:0]  e_width = '0;
    logic        e_read = 1'b0, e_write = 1'b0;
    logic [31:0] e_rdata = exp_rdata;
    logic [65:0] a66, x66;
    logic [37:0] a38, x38;
    use_fixed = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      cyc();
      n_checks++;
      if (phase == 1) begin
        a66 = {busy, io_read, io_write, grant_id, io_addr, io_data_in, io_width, ack};
        x66 = {1'b1, e_read & ~e_write, e_write, 2'(g), e_addr, e_wdata, e_width, 3'b000};
        if (a66 !== x66) begin n_fail++; $display("FAIL rand_access: cycle %0d got %h want %h", c, a66, x66); end
      end else if (phase == 2) begin
        a38 = {busy, io_read, io_write, ack, rdata};
        x38 = {3'b100, 3'(1 << g), e_rdata};
        if (a38 !== x38) begin n_fail++; $display("FAIL rand_resp: cycle %0d got %h want %h", c, a38, x38); end
      end else if ({busy, io_read, io_write, ack} !== 6'b0) begin
        n_fail++; $display("FAIL rand_idle: cycle %0d got %b want 000000", c, {busy, io_read, io_write, ack});
      end
      if (phase == 2) begin
        if ($urandom_range(1, 0) == 1) new_req(g);
        else req[g] = 1'b0;
      end
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(2, 0) == 0) new_req(i);
      case (phase)
        0: begin
          w = model_pick(req);
          if (w >= 0) begin
            g = w; e_addr = s_addr[g]; e_wdata = s_wdata[g]; e_width = s_width[g];
            e_read = s_read[g]; e_write = s_write[g];
            phase = 1;
          end
        end
        1: begin
          if (e_read && !e_write) e_rdata = io_fn(e_addr);
          phase = 2;
        end
        default: phase = 0;
      endcase
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_rw_both();
    test_reset_mid();
    test_drop_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
